// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus bundle between a master/decoder and the SRAM slave.
interface ahb_sram_slave_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  hsel;
    logic [31:0]           haddr;
    logic [1:0]            htrans;
    logic                  hwrite;
    logic [2:0]            hsize;
    logic [DATA_WIDTH-1:0] hwdata;
    logic                  hready;
    logic [DATA_WIDTH-1:0] hrdata;
    logic                  hreadyout;
    logic [1:0]            hresp;

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        output hrdata, hreadyout, hresp
    );

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        input  hrdata, hreadyout, hresp
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// Parametrised AHB-Lite SRAM slave: pipelined address/data phases, byte-lane
// writes, NONSEQ wait states, zero-wait SEQ beats and a two-cycle ERROR response.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_DATA | ready; completes zero-wait and post-wait data phases
// S_WAIT | NONSEQ wait states, counter runs down to 0
// S_ERR1 | first ERROR cycle, HREADYOUT low
// S_ERR2 | second ERROR cycle, HREADYOUT high, may accept a new phase
module ahb_sram_slave #(
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 2
) (
    input logic           hclk,
    input logic           hreset,
    ahb_sram_slave_if.slave bus
);
    localparam int NB  = DATA_WIDTH / 8;
    localparam int LSB = $clog2(NB);
    localparam int IW  = $clog2(MEM_DEPTH);
    localparam bit HAS_WAIT = (WAIT_STATES > 0);
    localparam logic [2:0] WAIT_LOAD = HAS_WAIT ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [1:0] {S_DATA, S_WAIT, S_ERR1, S_ERR2} state_t;

    state_t state, state_nxt;
    logic [2:0] cnt;
    logic       readyout;
    logic [1:0] resp;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic            accept, addr_err, range_err, size_err, align_err;
    logic [7:0]      size_bytes;
    logic [LSB-1:0]  lane;
    logic [IW-1:0]   idx;
    logic [NB-1:0]   strb;
    logic            nonseq_wait;

    // Registered data-phase attributes of an accepted OKAY transfer
    logic            dp_valid;
    logic            dp_write;
    logic [IW-1:0]   dp_idx;
    logic [NB-1:0]   dp_strb;

    logic            commit;
    logic            rd_zero_wait, rd_after_wait;
    logic [DATA_WIDTH-1:0] rd_next, rdata_q;

    assign size_bytes  = 8'd1 << bus.hsize;
    assign lane        = bus.haddr[LSB-1:0];
    assign idx         = bus.haddr[LSB+IW-1:LSB];
    assign range_err   = (bus.haddr >> (LSB + IW)) != 32'd0;
    assign size_err    = {24'd0, size_bytes} > 32'(NB);
    assign align_err   = (bus.haddr[7:0] & (size_bytes - 8'd1)) != 8'd0;
    assign addr_err    = range_err | size_err | align_err;

    assign readyout    = (state == S_DATA) || (state == S_ERR2);
    assign resp        = ((state == S_ERR1) || (state == S_ERR2)) ? 2'b01 : 2'b00;
    assign accept      = bus.hsel & bus.htrans[1] & bus.hready & readyout;
    assign nonseq_wait = HAS_WAIT && !bus.htrans[0];

    // A write commits on the edge that ends its (ready, OKAY) data phase
    assign commit        = (state == S_DATA) && dp_valid && dp_write;
    assign rd_zero_wait  = accept && !addr_err && !bus.hwrite && !nonseq_wait;
    assign rd_after_wait = (state == S_WAIT) && (cnt == 3'd0) && !dp_write;

    // Byte strobes: (1<<HSIZE) consecutive lanes starting at the address lane
    always_comb begin
        strb = '0;
        for (int b = 0; b < NB; b++) begin
            if (b >= int'(lane) && b < int'(lane) + int'(size_bytes)) begin
                strb[b] = 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state <= S_DATA;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            S_DATA, S_ERR2: begin
                state_nxt = S_DATA;
                if (accept) begin
                    if (addr_err) begin
                        state_nxt = S_ERR1;
                    end else if (nonseq_wait) begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 3'd0) begin
                    state_nxt = S_DATA;
                end
            end
            S_ERR1:  state_nxt = S_ERR2;
            default: state_nxt = S_DATA;
        endcase
    end

    // Wait-state down-counter, loaded on entry to S_WAIT
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            cnt <= 3'd0;
        end else if (state_nxt == S_WAIT && state != S_WAIT) begin
            cnt <= WAIT_LOAD;
        end else if (state == S_WAIT && cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
        end
    end

    // Capture the address phase whenever the slave is ready to move on
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_idx   <= '0;
            dp_strb  <= '0;
        end else if (readyout) begin
            dp_valid <= accept && !addr_err;
            dp_write <= bus.hwrite;
            dp_idx   <= idx;
            dp_strb  <= strb;
        end
    end

    // RAM write port; contents survive reset
    always_ff @(posedge hclk) begin
        if (commit) begin
            for (int b = 0; b < NB; b++) begin
                if (dp_strb[b]) begin
                    mem[dp_idx][8*b +: 8] <= bus.hwdata[8*b +: 8];
                end
            end
        end
    end

    // Read word for the next cycle; lanes outside the transfer read as zero and a
    // same-word write committing on this edge is forwarded lane by lane
    always_comb begin
        rd_next = '0;
        for (int b = 0; b < NB; b++) begin
            if (rd_zero_wait) begin
                if (strb[b]) begin
                    rd_next[8*b +: 8] = (commit && dp_idx == idx && dp_strb[b]) ?
                                        bus.hwdata[8*b +: 8] : mem[idx][8*b +: 8];
                end
            end else if (rd_after_wait) begin
                if (dp_strb[b]) begin
                    rd_next[8*b +: 8] = mem[dp_idx][8*b +: 8];
                end
            end
        end
    end

    // Read data register, zero except in a completing OKAY read cycle
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rd_next;
        end
    end

    assign bus.hreadyout = readyout;
    assign bus.hresp     = resp;
    assign bus.hrdata    = rdata_q;
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: a 32-bit/2-wait instance and a 64-bit/0-wait
// instance driven by a pipelined AHB master with a byte-level reference memory.
module tb_ahb_sram_slave;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ahb_sram_slave_if #(.DATA_WIDTH(32)) bus_a ();
    ahb_sram_slave_if #(.DATA_WIDTH(64)) bus_b ();

    assign bus_a.hready = bus_a.hreadyout;
    assign bus_b.hready = bus_b.hreadyout;

    ahb_sram_slave #(.DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(2)) dut_a (
        .hclk(clk), .hreset(rst), .bus(bus_a)
    );
    ahb_sram_slave #(.DATA_WIDTH(64), .MEM_DEPTH(256), .WAIT_STATES(0)) dut_b (
        .hclk(clk), .hreset(rst), .bus(bus_b)
    );

    typedef struct packed {
        logic        sel;
        logic [1:0]  tr;
        logic        wr;
        logic [2:0]  sz;
        logic [31:0] ad;
        logic [63:0] wd;
    } item_t;

    typedef struct packed {
        logic [63:0] rd;
        logic [31:0] waits;
        logic [1:0]  resp;
    } exp_t;

    localparam logic [1:0] IDL = 2'b00, BSY = 2'b01, NS = 2'b10, SQ = 2'b11;

    int errors = 0;
    int checks = 0;
    item_t items[$];
    exp_t  exq[$];
    logic [7:0] mdl [2][2048];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic add(input logic sel, input logic [1:0] tr, input logic wr,
                       input logic [2:0] sz, input logic [31:0] ad, input logic [63:0] wd);
        item_t it;
        it.sel = sel; it.tr = tr; it.wr = wr; it.sz = sz; it.ad = ad; it.wd = wd;
        items.push_back(it);
    endtask

    task automatic drive_addr(input int b, input item_t it);
        if (b == 0) begin
            bus_a.hsel = it.sel; bus_a.haddr = it.ad; bus_a.htrans = it.tr;
            bus_a.hwrite = it.wr; bus_a.hsize = it.sz;
        end else begin
            bus_b.hsel = it.sel; bus_b.haddr = it.ad; bus_b.htrans = it.tr;
            bus_b.hwrite = it.wr; bus_b.hsize = it.sz;
        end
    endtask

    task automatic drive_wdata(input int b, input logic [63:0] wd);
        if (b == 0) bus_a.hwdata = wd[31:0];
        else        bus_b.hwdata = wd;
    endtask

    task automatic sample(input int b, output logic ro, output logic [1:0] rs,
                          output logic [63:0] rd);
        if (b == 0) begin
            ro = bus_a.hreadyout; rs = bus_a.hresp; rd = {32'd0, bus_a.hrdata};
        end else begin
            ro = bus_b.hreadyout; rs = bus_b.hresp; rd = bus_b.hrdata;
        end
    endtask

    // Reference: byte-addressed memory; returns what the data phase must look like
    function automatic exp_t expect_of(input int b, input item_t it);
        exp_t e;
        int nb, ws, hi, nbytes, lane, base;
        bit err;
        nb = (b == 0) ? 4 : 8;
        ws = (b == 0) ? 2 : 0;
        hi = (b == 0) ? 10 : 11;
        e = '0;
        if (it.sel && it.tr[1]) begin
            nbytes = 1 << it.sz;
            err = ((it.ad >> hi) != 0) || (nbytes > nb) || ((it.ad % nbytes) != 0);
            if (err) begin
                e.waits = 1;
                e.resp  = 2'b01;
            end else begin
                e.waits = (it.tr == NS) ? ws : 0;
                lane = it.ad % nb;
                base = it.ad - lane;
                for (int k = 0; k < nbytes; k++) begin
                    if (it.wr) mdl[b][it.ad + k] = it.wd[8*(lane+k) +: 8];
                    else       e.rd[8*(lane+k) +: 8] = mdl[b][base + lane + k];
                end
            end
        end
        return e;
    endfunction

    // Pipelined master: issues queued items back to back and checks each data phase
    task automatic run(input int b);
        item_t cur;
        exp_t  dp;
        logic  dp_on, ro, adv;
        logic [1:0]  rs;
        logic [63:0] rd;
        int n, ai, dpi, waits, guard;
        n = items.size(); ai = 0; dpi = 0; waits = 0; guard = 0; dp_on = 1'b0;
        dp = '0;
        @(posedge clk); #1;
        cur = (n > 0) ? items[0] : '0;
        drive_addr(b, cur);
        exq.push_back(expect_of(b, cur));
        forever begin
            @(negedge clk);
            sample(b, ro, rs, rd);
            if (dp_on) begin
                chk($sformatf("b%0d it%0d resp", b, dpi), {62'd0, rs}, {62'd0, dp.resp});
                chk($sformatf("b%0d it%0d rdata", b, dpi), rd, ro ? dp.rd : 64'd0);
                if (!ro) waits++;
                else begin
                    chk($sformatf("b%0d it%0d waits", b, dpi), 64'(waits), 64'(dp.waits));
                    dp_on = 1'b0;
                end
            end
            adv = ro;
            guard++;
            if (guard > 400) begin
                checks++; errors++;
                $error("FAIL b%0d timeout observed=%0d cycles expected<=400", b, guard);
                break;
            end
            @(posedge clk); #1;
            if (adv) begin
                dpi = ai;
                dp = exq.pop_front();
                dp_on = 1'b1;
                waits = 0;
                drive_wdata(b, cur.wd);
                if (ai == n) break;
                ai++;
                cur = (ai < n) ? items[ai] : '0;
                drive_addr(b, cur);
                exq.push_back(expect_of(b, cur));
            end
        end
        items.delete();
        exq.delete();
    endtask

    initial begin
        logic ro;
        logic [1:0] rs;
        logic [63:0] rd;
        item_t w;
        drive_addr(0, '0); drive_addr(1, '0);
        drive_wdata(0, '0); drive_wdata(1, '0);
        #23;
        for (int b = 0; b < 2; b++) begin
            sample(b, ro, rs, rd);
            chk($sformatf("b%0d reset readyout", b), {63'd0, ro}, 64'd1);
            chk($sformatf("b%0d reset resp", b), {62'd0, rs}, 64'd0);
            chk($sformatf("b%0d reset rdata", b), rd, 64'd0);
        end
        rst = 1'b0;

        // 32-bit, 2 wait states: word write/read, byte write, halfword read
        add(1, NS, 1, 3'd2, 32'h10, 64'hDEADBEEF);
        add(1, IDL, 0, 3'd2, 32'h0, 64'h0);
        add(1, NS, 0, 3'd2, 32'h10, 64'h0);
        add(1, NS, 1, 3'd0, 32'h13, 64'hAA000000);
        add(1, NS, 0, 3'd1, 32'h12, 64'h0);
        // preload then SEQ read burst
        add(1, NS, 1, 3'd2, 32'h00, 64'h1);
        add(1, SQ, 1, 3'd2, 32'h04, 64'h2);
        add(1, SQ, 1, 3'd2, 32'h08, 64'h3);
        add(1, SQ, 1, 3'd2, 32'h0C, 64'h4);
        add(1, NS, 0, 3'd2, 32'h00, 64'h0);
        add(1, SQ, 0, 3'd2, 32'h04, 64'h0);
        add(1, BSY, 0, 3'd2, 32'h08, 64'h0);
        add(1, SQ, 0, 3'd2, 32'h08, 64'h0);
        add(1, SQ, 0, 3'd2, 32'h0C, 64'h0);
        // deselected write, then errors, then readback proving no access
        add(0, NS, 1, 3'd2, 32'h10, 64'h0);
        add(1, NS, 1, 3'd2, 32'h400, 64'h12345678);
        add(1, NS, 1, 3'd2, 32'h02, 64'h9ABCDEF0);
        add(1, NS, 1, 3'd3, 32'h08, 64'h55555555);
        add(1, NS, 0, 3'd3, 32'h08, 64'h0);
        add(1, NS, 0, 3'd2, 32'h00, 64'h0);
        add(1, NS, 0, 3'd2, 32'h08, 64'h0);
        add(1, NS, 0, 3'd2, 32'h10, 64'h0);
        run(0);

        // 64-bit, zero wait: forwarding and byte lanes
        add(1, NS, 1, 3'd2, 32'h20, 64'h11223344);
        add(1, NS, 0, 3'd2, 32'h20, 64'h0);
        add(1, NS, 1, 3'd0, 32'h21, 64'h0000_0000_0000_BB00);
        add(1, NS, 0, 3'd2, 32'h20, 64'h0);
        add(1, NS, 1, 3'd3, 32'h08, 64'h0102030405060708);
        for (int k = 8; k < 16; k++) add(1, NS, 0, 3'd0, 32'(k), 64'h0);
        add(1, NS, 0, 3'd3, 32'h08, 64'h0);
        add(1, NS, 1, 3'd3, 32'h800, 64'hFFFF);
        add(1, NS, 0, 3'd2, 32'h0C, 64'h0);
        run(1);

        // asynchronous reset while a write sits in its wait states
        @(posedge clk); #1;
        w = '0; w.sel = 1; w.tr = NS; w.wr = 1; w.sz = 3'd2; w.ad = 32'h10; w.wd = 64'h55555555;
        drive_addr(0, w);
        @(posedge clk); #1;
        drive_wdata(0, w.wd);
        drive_addr(0, '0);
        @(negedge clk);
        sample(0, ro, rs, rd);
        chk("pre-reset readyout", {63'd0, ro}, 64'd0);
        #2 rst = 1'b1;
        #1 sample(0, ro, rs, rd);
        chk("async reset readyout", {63'd0, ro}, 64'd1);
        chk("async reset resp", {62'd0, rs}, 64'd0);
        chk("async reset rdata", rd, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        add(1, NS, 0, 3'd2, 32'h10, 64'h0);
        add(1, NS, 0, 3'd2, 32'h04, 64'h0);
        run(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
